// File: rtl/msrv32_operand_stage.sv
// Operand stage: register file with write-through bypass, operand muxing
// and the registered operand bundle handed to the ALU stage.
module msrv32_operand_stage #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    input  logic [4:0]      rs1_addr_in,
    input  logic [4:0]      rs2_addr_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] imm_in,
    input  logic            op1_sel_in,
    input  logic            op2_sel_in,
    input  logic [3:0]      alu_opcode_in,
    input  logic            valid_in,
    input  logic            stall_in,
    input  logic            flush_in,
    input  logic            wb_en_in,
    input  logic [4:0]      rd_addr_in,
    input  logic [XLEN-1:0] rd_data_in,
    output logic [XLEN-1:0] op_1_out,
    output logic [XLEN-1:0] op_2_out,
    output logic [XLEN-1:0] rs2_data_out,
    output logic [3:0]      opcode_out,
    output logic            valid_out
);

    logic [XLEN-1:0] regs_q [NREGS];

    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;

    logic [XLEN-1:0] op1_q, op1_d;
    logic [XLEN-1:0] op2_q, op2_d;
    logic [XLEN-1:0] rs2_q, rs2_d;
    logic [3:0]      opc_q, opc_d;
    logic            valid_q, valid_d;

    logic wr_hit;

    assign wr_hit = wb_en_in && (rd_addr_in != 5'd0)
                    && (int'(rd_addr_in) < NREGS);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_hit) begin
            regs_q[rd_addr_in] <= rd_data_in;
        end
    end

    // x0 reads zero and is never bypassed; a matching write wins otherwise
    always_comb begin
        rs1_data = '0;
        if (rs1_addr_in != 5'd0) begin
            if (wb_en_in && (rd_addr_in == rs1_addr_in)) begin
                rs1_data = rd_data_in;
            end else if (int'(rs1_addr_in) < NREGS) begin
                rs1_data = regs_q[rs1_addr_in];
            end
        end
    end

    always_comb begin
        rs2_data = '0;
        if (rs2_addr_in != 5'd0) begin
            if (wb_en_in && (rd_addr_in == rs2_addr_in)) begin
                rs2_data = rd_data_in;
            end else if (int'(rs2_addr_in) < NREGS) begin
                rs2_data = regs_q[rs2_addr_in];
            end
        end
    end

    always_comb begin
        op1_d   = op1_q;
        op2_d   = op2_q;
        rs2_d   = rs2_q;
        opc_d   = opc_q;
        valid_d = valid_q;
        if (flush_in) begin
            op1_d   = '0;
            op2_d   = '0;
            rs2_d   = '0;
            opc_d   = '0;
            valid_d = 1'b0;
        end else if (!stall_in) begin
            op1_d   = op1_sel_in ? pc_in : rs1_data;
            op2_d   = op2_sel_in ? imm_in : rs2_data;
            rs2_d   = rs2_data;
            opc_d   = alu_opcode_in;
            valid_d = valid_in;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            op1_q   <= '0;
            op2_q   <= '0;
            rs2_q   <= '0;
            opc_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            rs2_q   <= rs2_d;
            opc_q   <= opc_d;
            valid_q <= valid_d;
        end
    end

    assign op_1_out     = op1_q;
    assign op_2_out     = op2_q;
    assign rs2_data_out = rs2_q;
    assign opcode_out   = opc_q;
    assign valid_out    = valid_q;

endmodule

// File: tb/tb_msrv32_operand_stage.sv
// Bench for msrv32_operand_stage: directed scenarios plus randomized
// traffic against an array-based reference model.
module tb_msrv32_operand_stage;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic [4:0]  rs1_addr_in, rs2_addr_in, rd_addr_in;
    logic [31:0] pc_in, imm_in, rd_data_in;
    logic        op1_sel_in, op2_sel_in;
    logic [3:0]  alu_opcode_in;
    logic        valid_in, stall_in, flush_in, wb_en_in;
    logic [31:0] op_1_out, op_2_out, rs2_data_out;
    logic [3:0]  opcode_out;
    logic        valid_out;

    int passed = 0;
    int total  = 0;

    logic [31:0] mem [32];
    logic [31:0] e_op1, e_op2, e_rs2;
    logic [3:0]  e_opc;
    logic        e_vld;

    msrv32_operand_stage dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .rs1_addr_in(rs1_addr_in), .rs2_addr_in(rs2_addr_in),
        .pc_in(pc_in), .imm_in(imm_in),
        .op1_sel_in(op1_sel_in), .op2_sel_in(op2_sel_in),
        .alu_opcode_in(alu_opcode_in), .valid_in(valid_in),
        .stall_in(stall_in), .flush_in(flush_in),
        .wb_en_in(wb_en_in), .rd_addr_in(rd_addr_in),
        .rd_data_in(rd_data_in),
        .op_1_out(op_1_out), .op_2_out(op_2_out),
        .rs2_data_out(rs2_data_out), .opcode_out(opcode_out),
        .valid_out(valid_out)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [31:0] mread(input logic [4:0] a);
        if (a == 0) return 32'd0;
        if (wb_en_in && rd_addr_in == a) return rd_data_in;
        return mem[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mem[i] = 32'd0;
        e_op1 = 0; e_op2 = 0; e_rs2 = 0; e_opc = 0; e_vld = 0;
    endtask

    task automatic idle();
        rs1_addr_in = 0; rs2_addr_in = 0; rd_addr_in = 0;
        pc_in = 0; imm_in = 0; rd_data_in = 0;
        op1_sel_in = 0; op2_sel_in = 0; alu_opcode_in = 0;
        valid_in = 0; stall_in = 0; flush_in = 0; wb_en_in = 0;
    endtask

    // Predict the edge from current inputs, take the edge, commit the write.
    task automatic tick();
        logic [31:0] r1, r2;
        r1 = mread(rs1_addr_in);
        r2 = mread(rs2_addr_in);
        if (flush_in) begin
            e_op1 = 0; e_op2 = 0; e_rs2 = 0; e_opc = 0; e_vld = 0;
        end else if (!stall_in) begin
            e_op1 = op1_sel_in ? pc_in : r1;
            e_op2 = op2_sel_in ? imm_in : r2;
            e_rs2 = r2;
            e_opc = alu_opcode_in;
            e_vld = valid_in;
        end
        @(posedge clk_in);
        if (wb_en_in && rd_addr_in != 0) mem[rd_addr_in] = rd_data_in;
        #1;
    endtask

    task automatic test_reset();
        total++;
        if ({op_1_out, op_2_out, rs2_data_out, opcode_out, valid_out} !== '0)
            $display("FAIL reset_initial got %h %h %h %h %b want 0",
                     op_1_out, op_2_out, rs2_data_out, opcode_out, valid_out);
        else passed++;
        idle();
        wb_en_in = 1; rd_addr_in = 5; rd_data_in = 32'hDEAD_BEEF;
        tick();
        idle();
        rs1_addr_in = 5; rs2_addr_in = 5; valid_in = 1; alu_opcode_in = 4'h7;
        tick();
        total++;
        if (op_1_out !== 32'hDEAD_BEEF || valid_out !== 1'b1)
            $display("FAIL reset_preload got %h %b want deadbeef 1",
                     op_1_out, valid_out);
        else passed++;
        // Mid-cycle reset with a write pending on the inputs
        wb_en_in = 1; rd_addr_in = 9; rd_data_in = 32'h1234_5678;
        #2 rst_n_in = 0;
        #1;
        total++;
        if ({op_1_out, op_2_out, rs2_data_out, opcode_out, valid_out} !== '0)
            $display("FAIL reset_async got %h %h %h %h %b want 0",
                     op_1_out, op_2_out, rs2_data_out, opcode_out, valid_out);
        else passed++;
        model_reset();
        rst_n_in = 1;
        idle();
        rs1_addr_in = 5; rs2_addr_in = 9; valid_in = 1;
        tick();
        total++;
        if (op_1_out !== 32'd0 || rs2_data_out !== 32'd0 || valid_out !== 1'b1)
            $display("FAIL reset_x5_cleared got %h %h %b want 0 0 1",
                     op_1_out, rs2_data_out, valid_out);
        else passed++;
    endtask

    task automatic test_write_read();
        idle();
        wb_en_in = 1; rd_addr_in = 3; rd_data_in = 32'h0000_000A;
        tick();
        idle();
        rs1_addr_in = 3; rs2_addr_in = 0; op2_sel_in = 1; imm_in = 20;
        alu_opcode_in = 4'b0000; valid_in = 1;
        tick();
        total++;
        if ({op_1_out, op_2_out, opcode_out, valid_out}
            !== {32'd10, 32'd20, 4'd0, 1'b1})
            $display("FAIL write_read got %h %h %h %b want a 14 0 1",
                     op_1_out, op_2_out, opcode_out, valid_out);
        else passed++;
    endtask

    task automatic test_bypass();
        idle();
        wb_en_in = 1; rd_addr_in = 7; rd_data_in = 32'h8000_0000;
        rs1_addr_in = 7; rs2_addr_in = 7; valid_in = 1;
        tick();
        total++;
        if ({op_1_out, op_2_out, rs2_data_out}
            !== {3{32'h8000_0000}})
            $display("FAIL bypass got %h %h %h want 80000000 x3",
                     op_1_out, op_2_out, rs2_data_out);
        else passed++;
    endtask

    task automatic test_x0();
        idle();
        wb_en_in = 1; rd_addr_in = 0; rd_data_in = 32'hFFFF_FFFF;
        rs1_addr_in = 0; rs2_addr_in = 0; valid_in = 1;
        tick();
        total++;
        if (op_1_out !== 32'd0 || rs2_data_out !== 32'd0)
            $display("FAIL x0_bypass got %h %h want 0 0",
                     op_1_out, rs2_data_out);
        else passed++;
        idle();
        rs1_addr_in = 0; valid_in = 1;
        tick();
        total++;
        if (op_1_out !== 32'd0)
            $display("FAIL x0_read got %h want 0", op_1_out);
        else passed++;
    endtask

    task automatic test_stall_flush();
        idle();
        wb_en_in = 1; rd_addr_in = 4; rd_data_in = 32'd30;
        tick();
        idle();
        rs1_addr_in = 4; rs2_addr_in = 4; valid_in = 1; alu_opcode_in = 4'h3;
        tick();
        total++;
        if (op_1_out !== 32'd30 || valid_out !== 1'b1)
            $display("FAIL stall_load got %h %b want 1e 1",
                     op_1_out, valid_out);
        else passed++;
        stall_in = 1; rs1_addr_in = 0; op2_sel_in = 1; imm_in = 99;
        alu_opcode_in = 4'h9; valid_in = 0;
        tick();
        tick();
        total++;
        if ({op_1_out, op_2_out, rs2_data_out, opcode_out, valid_out}
            !== {32'd30, 32'd30, 32'd30, 4'h3, 1'b1})
            $display("FAIL stall_hold got %h %h %h %h %b want 1e 1e 1e 3 1",
                     op_1_out, op_2_out, rs2_data_out, opcode_out, valid_out);
        else passed++;
        flush_in = 1;
        tick();
        total++;
        if ({op_1_out, op_2_out, rs2_data_out, opcode_out, valid_out} !== '0)
            $display("FAIL flush_over_stall got %h %h %h %h %b want 0",
                     op_1_out, op_2_out, rs2_data_out, opcode_out, valid_out);
        else passed++;
    endtask

    task automatic test_pc_select();
        idle();
        op1_sel_in = 1; pc_in = 32'h0000_0100;
        op2_sel_in = 1; imm_in = 4; rs2_addr_in = 3; valid_in = 1;
        tick();
        total++;
        if ({op_1_out, op_2_out, rs2_data_out} !== {32'h100, 32'd4, 32'd10})
            $display("FAIL pc_select got %h %h %h want 100 4 a",
                     op_1_out, op_2_out, rs2_data_out);
        else passed++;
    endtask

    task automatic test_invalid_load();
        idle();
        rs1_addr_in = 3; alu_opcode_in = 4'h5; valid_in = 0;
        tick();
        total++;
        if (op_1_out !== 32'd10 || opcode_out !== 4'h5 || valid_out !== 1'b0)
            $display("FAIL invalid_load got %h %h %b want a 5 0",
                     op_1_out, opcode_out, valid_out);
        else passed++;
    endtask

    task automatic test_random();
        int errs = 0;
        for (int n = 0; n < 400; n++) begin
            rd_addr_in    = 5'($urandom_range(0, 31));
            rs1_addr_in   = ($urandom_range(0, 3) == 0) ? rd_addr_in
                            : 5'($urandom_range(0, 31));
            rs2_addr_in   = ($urandom_range(0, 3) == 0) ? rd_addr_in
                            : 5'($urandom_range(0, 31));
            rd_data_in    = $urandom;
            pc_in         = $urandom;
            imm_in        = $urandom;
            op1_sel_in    = 1'($urandom_range(0, 1));
            op2_sel_in    = 1'($urandom_range(0, 1));
            alu_opcode_in = 4'($urandom_range(0, 15));
            valid_in      = 1'($urandom_range(0, 1));
            wb_en_in      = ($urandom_range(0, 2) != 0);
            stall_in      = ($urandom_range(0, 3) == 0);
            flush_in      = ($urandom_range(0, 7) == 0);
            tick();
            total++;
            if ({op_1_out, op_2_out, rs2_data_out, opcode_out, valid_out}
                !== {e_op1, e_op2, e_rs2, e_opc, e_vld}) begin
                if (errs < 10)
                    $display("FAIL random[%0d] got %h %h %h %h %b want %h %h %h %h %b",
                             n, op_1_out, op_2_out, rs2_data_out, opcode_out,
                             valid_out, e_op1, e_op2, e_rs2, e_opc, e_vld);
                errs++;
            end else passed++;
        end
    endtask

    initial begin
        idle();
        model_reset();
        rst_n_in = 0;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        rst_n_in = 1;
        @(posedge clk_in);
        #1;
        test_reset();
        test_write_read();
        test_bypass();
        test_x0();
        test_stall_flush();
        test_pc_select();
        test_invalid_load();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/msrv32_operand_stage.md
MSRV32_OPERAND_STAGE -- requirements
Module: msrv32_operand_stage

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the datapath width of registers, operands and immediates.
REQ-002 The block SHALL have parameter NREGS, default 32, giving the register count; the register index is 5 bits.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Port clk_in, input, 1 bit: rising-edge clock for all state.
REQ-005 Port rst_n_in, input, 1 bit: asynchronous active-low reset.
REQ-006 Port rs1_addr_in, input, 5 bits: index of source register 1.
REQ-007 Port rs2_addr_in, input, 5 bits: index of source register 2.
REQ-008 Port pc_in, input, XLEN bits: PC of the issuing instruction.
REQ-009 Port imm_in, input, XLEN bits: decoded immediate.
REQ-010 Port op1_sel_in, input, 1 bit: selects operand 1 source (0 = rs1 data, 1 = pc_in).
REQ-011 Port op2_sel_in, input, 1 bit: selects operand 2 source (0 = rs2 data, 1 = imm_in).
REQ-012 Port alu_opcode_in, input, 4 bits: ALU opcode passed through to the ALU.
REQ-013 Port valid_in, input, 1 bit: the issuing instruction is valid.
REQ-014 Port stall_in, input, 1 bit: hold the output registers.
REQ-015 Port flush_in, input, 1 bit: kill the output stage.
REQ-016 Port wb_en_in, input, 1 bit: write-back enable.
REQ-017 Port rd_addr_in, input, 5 bits: write-back destination register.
REQ-018 Port rd_data_in, input, XLEN bits: write-back data.
REQ-019 Port op_1_out, output, XLEN bits: registered ALU operand 1.
REQ-020 Port op_2_out, output, XLEN bits: registered ALU operand 2.
REQ-021 Port rs2_data_out, output, XLEN bits: registered raw rs2 value, used as store data.
REQ-022 Port opcode_out, output, 4 bits: registered ALU opcode.
REQ-023 Port valid_out, output, 1 bit: the output registers hold a live instruction.

Function
REQ-024 The block SHALL hold NREGS x XLEN registers; register x0 SHALL always read 0.
REQ-025 On a rising edge with wb_en_in=1 and rd_addr_in!=0, rd_data_in SHALL be written to register[rd_addr_in].
REQ-026 Writes with rd_addr_in=0 SHALL be ignored.
REQ-027 Write-back SHALL be independent of stall_in and flush_in.
REQ-028 Reads SHALL be combinational, with write-through bypass on each port independently: if wb_en_in=1, rd_addr_in==rsN_addr_in and rsN_addr_in!=0, the read data SHALL be rd_data_in; otherwise it SHALL be the stored value.
REQ-029 Operand 1 SHALL be pc_in when op1_sel_in=1, else the rs1 read data.
REQ-030 Operand 2 SHALL be imm_in when op2_sel_in=1, else the rs2 read data.
REQ-031 rs2_data_out SHALL always take the rs2 read data, regardless of op2_sel_in.
REQ-032 Latency SHALL be 1 cycle: when flush_in=0 and stall_in=0, each rising edge SHALL load op_1_out, op_2_out, rs2_data_out and opcode_out from the current selections, and valid_out from valid_in.
REQ-033 When flush_in=0 and stall_in=1, all output registers SHALL hold their values.
REQ-034 flush_in=1 SHALL take priority over stall_in: on the next edge valid_out, op_1_out, op_2_out, rs2_data_out and opcode_out SHALL all load 0.
REQ-035 When valid_in=0 and there is no stall or flush, data outputs SHALL still load and valid_out SHALL load 0.
REQ-036 Register index wrap-around SHALL not exist; the 5-bit index SHALL address exactly registers 0..31.
REQ-037 No output SHALL depend combinationally on any input; every output SHALL come straight from a flop.

Reset
REQ-038 When rst_n_in=0, asynchronously and regardless of clock, all NREGS registers and all outputs SHALL be 0; opcode_out=0 is ADD.
REQ-039 Reset asserted mid-stall or mid-write SHALL discard the pending write and the held outputs.
REQ-040 After rst_n_in deasserts, the first rising edge SHALL behave as a normal cycle.

Verification
REQ-041 Scenario, reset: pulse rst_n_in low between edges -> all outputs 0 immediately; read of x5 afterwards returns 0.
REQ-042 Scenario, write then read: write x3=32'h0000000A; next cycle rs1=3, rs2=0, op2_sel=1, imm=20, opcode=4'b0000, valid=1 -> next edge op_1_out=10, op_2_out=20, opcode_out=0, valid_out=1.
REQ-043 Scenario, bypass: in the same cycle wb_en=1, rd=7, rd_data=32'h80000000, rs1=7, rs2=7, op2_sel=0 -> op_1_out=op_2_out=rs2_data_out=32'h80000000.
REQ-044 Scenario, x0: write rd=0 with data 32'hFFFFFFFF, then read rs1=0 -> op_1_out=0; the same-cycle bypass from rd=0 does not apply.
REQ-045 Scenario, stall/flush: after a load of op_1_out=30, assert stall_in=1 and change inputs -> outputs stay 30 / valid_out=1; assert stall_in=1 and flush_in=1 -> next edge all outputs 0 and valid_out=0.
REQ-046 Scenario, PC select: op1_sel=1, pc_in=32'h00000100, op2_sel=1, imm=4 -> op_1_out=32'h100, op_2_out=4.
